// File: rtl/mix_tx_unit_pkg.sv
// Shared constants, unit numbers and FSM encoding for the MIX serial transmit unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mix_tx_unit_pkg;

  localparam int MIX_CHAR_BITS  = 6;
  localparam int CHARS_PER_WORD = 5;

  // MIX device numbers with a fixed block length
  localparam logic [5:0] UNIT_CARD_READER = 6'd16;
  localparam logic [5:0] UNIT_CARD_PUNCH  = 6'd17;
  localparam logic [5:0] UNIT_PRINTER     = 6'd18;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_EOL,
    ST_DONE
  } tx_state_e;

  // Number of words moved by one OUT to the given unit
  function automatic logic [5:0] block_words(input logic [5:0] unit,
                                             input logic [5:0] dflt);
    case (unit)
      UNIT_CARD_READER: block_words = 6'd16;
      UNIT_CARD_PUNCH:  block_words = 6'd16;
      UNIT_PRINTER:     block_words = 6'd24;
      default:          block_words = dflt;
    endcase
  endfunction

endpackage

// File: rtl/mix_char_to_ascii.sv
// MIX 6-bit character code to 8-bit ASCII translation table.
// Latency: purely combinational.
// Backpressure: none.
module mix_char_to_ascii import mix_tx_unit_pkg::*; (
  input  logic [MIX_CHAR_BITS-1:0] code,
  output logic [7:0]               ascii
);

  logic [7:0] code8;

  assign code8 = 8'(code);

  // Letter and digit runs are contiguous in ASCII, so they are offset; the rest is a lookup
  always_comb begin
    ascii = 8'h3F;
    if (code == 6'd0)        ascii = 8'h20;
    else if (code <= 6'd9)   ascii = code8 + 8'h40;  // 1 -> 'A'
    else if (code == 6'd10)  ascii = 8'h7E;
    else if (code <= 6'd19)  ascii = code8 + 8'h3F;  // 11 -> 'J'
    else if (code == 6'd20)  ascii = 8'h5B;
    else if (code == 6'd21)  ascii = 8'h23;
    else if (code <= 6'd29)  ascii = code8 + 8'h3D;  // 22 -> 'S'
    else if (code <= 6'd39)  ascii = code8 + 8'h12;  // 30 -> '0'
    else begin
      case (code)
        6'd40:   ascii = 8'h2E;
        6'd41:   ascii = 8'h2C;
        6'd42:   ascii = 8'h28;
        6'd43:   ascii = 8'h29;
        6'd44:   ascii = 8'h2B;
        6'd45:   ascii = 8'h2D;
        6'd46:   ascii = 8'h2A;
        6'd47:   ascii = 8'h2F;
        6'd48:   ascii = 8'h3D;
        6'd49:   ascii = 8'h24;
        6'd50:   ascii = 8'h3C;
        6'd51:   ascii = 8'h3E;
        6'd52:   ascii = 8'h40;
        6'd53:   ascii = 8'h3B;
        6'd54:   ascii = 8'h3A;
        6'd55:   ascii = 8'h27;
        default: ascii = 8'h3F;
      endcase
    end
  end

endmodule

// File: rtl/mix_tx_unit.sv
// MIX OUT device: fetches a block of words and sends each as five ASCII chars over UART 8N1.
// Latency: stop/busy one cycle after accepting start; first start bit the cycle after load.
// Backpressure: one pending OUT is queued while busy, further starts are dropped; memory waits on load.
module mix_tx_unit import mix_tx_unit_pkg::*; #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int EOL           = 1,
  parameter int DEFAULT_WORDS = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  field,
  input  logic [11:0] addressin,
  output logic        stop,
  output logic        busy,
  output logic        request,
  output logic [11:0] addressout,
  input  logic        load,
  input  logic [29:0] in,
  output logic        tx
);

  localparam int              CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [5:0]      DFLT_WORDS = 6'(DEFAULT_WORDS);
  localparam logic [2:0]      CHARS_REST = 3'(CHARS_PER_WORD - 1);

  tx_state_e     state;
  logic [5:0]    words_left;
  logic [23:0]   char_shift;   // characters of the current word not yet framed
  logic [2:0]    chars_left;
  logic [8:0]    frame;        // data bits then stop bit, shifted out LSB first
  logic [3:0]    bits_left;
  logic [CW-1:0] clk_cnt;
  logic          eol_lf;

  logic          pend_vld;
  logic [5:0]    pend_field;
  logic [11:0]   pend_addr;

  logic [5:0]    map_code;
  logic [7:0]    map_ascii;
  logic          acc_go;
  logic [5:0]    acc_field;
  logic [11:0]   acc_addr;
  logic          bit_end;

  // The first character of a word is translated straight off the memory bus
  always_comb begin
    map_code = char_shift[23:18];
    if (state == ST_FETCH) map_code = in[29:24];
  end

  mix_char_to_ascii u_char_map (
    .code  (map_code),
    .ascii (map_ascii)
  );

  assign bit_end   = (clk_cnt == '0);
  assign acc_go    = pend_vld | start;
  assign acc_field = pend_vld ? pend_field : field;
  assign acc_addr  = pend_vld ? pend_addr  : addressin;

  // Command acceptance, word fetch, and UART framing in one registered FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      stop       <= 1'b0;
      busy       <= 1'b0;
      request    <= 1'b0;
      addressout <= 12'd0;
      tx         <= 1'b1;
      words_left <= 6'd0;
      char_shift <= 24'd0;
      chars_left <= 3'd0;
      frame      <= 9'h1FF;
      bits_left  <= 4'd0;
      clk_cnt    <= '0;
      eol_lf     <= 1'b0;
      pend_vld   <= 1'b0;
      pend_field <= 6'd0;
      pend_addr  <= 12'd0;
    end else begin
      stop <= 1'b0;

      if (start && (state != ST_IDLE) && !pend_vld) begin
        pend_vld   <= 1'b1;
        pend_field <= field;
        pend_addr  <= addressin;
      end

      case (state)
        ST_IDLE: begin
          if (acc_go) begin
            state      <= ST_FETCH;
            busy       <= 1'b1;
            stop       <= 1'b1;
            request    <= 1'b1;
            addressout <= acc_addr;
            words_left <= block_words(acc_field, DFLT_WORDS);
            // Pending OUT consumed; a simultaneous start refills the slot
            if (pend_vld) begin
              pend_vld   <= start;
              pend_field <= field;
              pend_addr  <= addressin;
            end
          end
        end

        ST_FETCH: begin
          if (load) begin
            state      <= ST_SEND;
            request    <= 1'b0;
            char_shift <= in[23:0];
            chars_left <= CHARS_REST;
            tx         <= 1'b0;
            frame      <= {1'b1, map_ascii};
            bits_left  <= 4'd9;
            clk_cnt    <= BIT_LAST;
          end
        end

        ST_SEND, ST_EOL: begin
          if (!bit_end) begin
            clk_cnt <= clk_cnt - 1'b1;
          end else if (bits_left != 4'd0) begin
            tx        <= frame[0];
            frame     <= {1'b1, frame[8:1]};
            bits_left <= bits_left - 1'b1;
            clk_cnt   <= BIT_LAST;
          end else if ((state == ST_SEND) && (chars_left != 3'd0)) begin
            char_shift <= {char_shift[17:0], 6'd0};
            chars_left <= chars_left - 1'b1;
            tx         <= 1'b0;
            frame      <= {1'b1, map_ascii};
            bits_left  <= 4'd9;
            clk_cnt    <= BIT_LAST;
          end else if (state == ST_SEND) begin
            addressout <= addressout + 1'b1;
            words_left <= words_left - 1'b1;
            if (words_left != 6'd1) begin
              state   <= ST_FETCH;
              request <= 1'b1;
            end else if (EOL != 0) begin
              state     <= ST_EOL;
              eol_lf    <= 1'b0;
              tx        <= 1'b0;
              frame     <= {1'b1, ASCII_CR};
              bits_left <= 4'd9;
              clk_cnt   <= BIT_LAST;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end
          end else if (!eol_lf) begin
            eol_lf    <= 1'b1;
            tx        <= 1'b0;
            frame     <= {1'b1, ASCII_LF};
            bits_left <= 4'd9;
            clk_cnt   <= BIT_LAST;
          end else begin
            state <= ST_DONE;
            busy  <= 1'b0;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
